// File: rtl/jump_charge_ctrl_if.sv
// rtl/jump_charge_ctrl_if.sv - game-side / controller-side signal bundle for the jump charge controller
interface jump_charge_ctrl_if #(
  parameter int PHY_WIDTH = 16
);
  logic                 tick;
  logic                 jump_btn;
  logic                 on_ground;
  logic [PHY_WIDTH-1:0] charge_cnt;
  logic                 charging;
  logic                 jump_fire;
  logic [PHY_WIDTH-1:0] jump_power;

  modport master (
    output tick, jump_btn, on_ground,
    input  charge_cnt, charging, jump_fire, jump_power
  );

  modport slave (
    input  tick, jump_btn, on_ground,
    output charge_cnt, charging, jump_fire, jump_power
  );
endinterface

// File: rtl/jump_charge_ctrl.sv
// rtl/jump_charge_ctrl.sv - press-and-hold jump charge FSM with saturating charge and post-fire cooldown
module jump_charge_ctrl #(
  parameter int PHY_WIDTH      = 16,
  parameter int MAX_CHARGE     = 40,
  parameter int MIN_CHARGE     = 2,
  parameter int COOLDOWN_TICKS = 4
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  jump_charge_ctrl_if.slave bus
);

  localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0]      CD_LAST = CD_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
  localparam logic [PHY_WIDTH-1:0] MAX_C   = PHY_WIDTH'(MAX_CHARGE);
  localparam logic [PHY_WIDTH-1:0] MIN_C   = PHY_WIDTH'(MIN_CHARGE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    CHARGE   = 3'd2,
    FIRE     = 3'd3,
    COOLDOWN = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PHY_WIDTH-1:0] charge_cnt_q, charge_cnt_d;
  logic [PHY_WIDTH-1:0] jump_power_q, jump_power_d;
  logic                 jump_fire_q, jump_fire_d;
  logic                 charging_q, charging_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 btn_prev_q, btn_prev_d;
  logic                 btn_valid_q, btn_valid_d;
  logic                 btn_rise;

  // btn_valid_q masks the first post-reset sample so a button held through reset is not seen as a press
  assign btn_rise = bus.jump_btn & ~btn_prev_q & btn_valid_q;

  always_comb begin
    state_d      = state_q;
    charge_cnt_d = charge_cnt_q;
    jump_power_d = jump_power_q;
    jump_fire_d  = 1'b0;
    cd_d         = cd_q;
    btn_prev_d   = bus.jump_btn;
    btn_valid_d  = 1'b1;

    case (state_q)
      IDLE: begin
        charge_cnt_d = '0;
        cd_d         = '0;
        if (btn_rise) begin
          state_d = bus.on_ground ? CHARGE : ARMED;
        end
      end
      ARMED: begin
        charge_cnt_d = '0;
        if (!bus.jump_btn) begin
          state_d = IDLE;
        end else if (bus.on_ground) begin
          state_d = CHARGE;
        end
      end
      CHARGE: begin
        // leaving the platform beats a release in the same cycle; release beats a tick
        if (!bus.on_ground) begin
          state_d      = IDLE;
          charge_cnt_d = '0;
        end else if (!bus.jump_btn) begin
          if (charge_cnt_q >= MIN_C) begin
            state_d      = FIRE;
            jump_fire_d  = 1'b1;
            jump_power_d = charge_cnt_q;
          end else begin
            state_d      = IDLE;
            charge_cnt_d = '0;
          end
        end else if (bus.tick && (charge_cnt_q < MAX_C)) begin
          charge_cnt_d = charge_cnt_q + PHY_WIDTH'(1);
        end
      end
      FIRE: begin
        charge_cnt_d = '0;
        cd_d         = '0;
        state_d      = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (bus.tick) begin
          if (cd_q == CD_LAST) begin
            state_d = IDLE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + CD_W'(1);
          end
        end
      end
      default: begin
        state_d      = IDLE;
        charge_cnt_d = '0;
        jump_power_d = '0;
        cd_d         = '0;
      end
    endcase

    charging_d = (state_d == CHARGE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      charge_cnt_q <= '0;
      jump_power_q <= '0;
      jump_fire_q  <= 1'b0;
      charging_q   <= 1'b0;
      cd_q         <= '0;
      btn_prev_q   <= 1'b0;
      btn_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      charge_cnt_q <= charge_cnt_d;
      jump_power_q <= jump_power_d;
      jump_fire_q  <= jump_fire_d;
      charging_q   <= charging_d;
      cd_q         <= cd_d;
      btn_prev_q   <= btn_prev_d;
      btn_valid_q  <= btn_valid_d;
    end
  end

  assign bus.charge_cnt = charge_cnt_q;
  assign bus.charging   = charging_q;
  assign bus.jump_fire  = jump_fire_q;
  assign bus.jump_power = jump_power_q;

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// tb/tb_jump_charge_ctrl.sv - directed self-checking bench for jump_charge_ctrl
module tb_jump_charge_ctrl;
  logic sys_clk;
  logic sys_rst_n;
  int   n_chk;
  int   n_pass;

  jump_charge_ctrl_if #(.PHY_WIDTH(16)) bus ();

  jump_charge_ctrl #(
    .PHY_WIDTH(16),
    .MAX_CHARGE(40),
    .MIN_CHARGE(2),
    .COOLDOWN_TICKS(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t);
    bus.tick = t;
    @(posedge sys_clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_cnt"}, 32'(bus.charge_cnt), 0);
    check({tag, "_chg"}, 32'(bus.charging), 0);
    check({tag, "_fire"}, 32'(bus.jump_fire), 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sys_rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.jump_btn = 1'b0;
    bus.on_ground = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    outs_zero("rst");
    check("rst_pwr", 32'(bus.jump_power), 0);
    sys_rst_n = 1'b1;
    step(0);

    // press on ground, 10 ticks, release
    bus.jump_btn = 1'b1;
    step(0);
    check("c10_start_chg", 32'(bus.charging), 1);
    check("c10_start_cnt", 32'(bus.charge_cnt), 0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("c10_cnt", 32'(bus.charge_cnt), 32'(i));
    end
    bus.jump_btn = 1'b0;
    step(0);
    check("c10_fire", 32'(bus.jump_fire), 1);
    check("c10_pwr", 32'(bus.jump_power), 10);
    check("c10_chg_off", 32'(bus.charging), 0);
    step(0);
    check("c10_fire_1clk", 32'(bus.jump_fire), 0);
    check("c10_cnt_clr", 32'(bus.charge_cnt), 0);
    check("c10_pwr_hold", 32'(bus.jump_power), 10);

    // cooldown: press after 3 ticks ignored, press after 4th tick accepted
    repeat (3) step(1);
    bus.jump_btn = 1'b1;
    step(0);
    check("cd_press_ign", 32'(bus.charging), 0);
    bus.jump_btn = 1'b0;
    step(0);
    step(1);
    check("cd_done_chg", 32'(bus.charging), 0);
    bus.jump_btn = 1'b1;
    step(0);
    check("cd_new_chg", 32'(bus.charging), 1);

    // saturation at 40
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (i == 39) check("sat_39", 32'(bus.charge_cnt), 39);
      if (i == 41) check("sat_41", 32'(bus.charge_cnt), 40);
    end
    check("sat_60", 32'(bus.charge_cnt), 40);
    bus.jump_btn = 1'b0;
    step(0);
    check("sat_fire", 32'(bus.jump_fire), 1);
    check("sat_pwr", 32'(bus.jump_power), 40);
    step(0);
    repeat (4) step(1);

    // 1 tick then release: too short
    bus.jump_btn = 1'b1;
    step(0);
    step(1);
    check("short1_cnt", 32'(bus.charge_cnt), 1);
    bus.jump_btn = 1'b0;
    step(0);
    outs_zero("short1");
    step(0);
    check("short1_late", 32'(bus.jump_fire), 0);

    // release coincides with 2nd tick: release wins, charge stays 1
    bus.jump_btn = 1'b1;
    step(0);
    step(1);
    bus.jump_btn = 1'b0;
    step(1);
    outs_zero("coinc");
    step(0);
    check("coinc_late", 32'(bus.jump_fire), 0);
    check("coinc_pwr", 32'(bus.jump_power), 40);

    // exactly MIN_CHARGE fires
    bus.jump_btn = 1'b1;
    step(0);
    step(1);
    step(1);
    bus.jump_btn = 1'b0;
    step(0);
    check("min_fire", 32'(bus.jump_fire), 1);
    check("min_pwr", 32'(bus.jump_power), 2);
    step(0);
    repeat (4) step(1);

    // airborne press, land held, then pushed off at charge 5
    bus.on_ground = 1'b0;
    bus.jump_btn = 1'b1;
    step(0);
    check("air_armed_chg", 32'(bus.charging), 0);
    repeat (3) step(1);
    check("air_hold_chg", 32'(bus.charging), 0);
    bus.on_ground = 1'b1;
    step(0);
    check("land_chg", 32'(bus.charging), 1);
    check("land_cnt", 32'(bus.charge_cnt), 0);
    repeat (5) step(1);
    check("push_cnt5", 32'(bus.charge_cnt), 5);
    bus.on_ground = 1'b0;
    step(0);
    outs_zero("push");
    bus.on_ground = 1'b1;
    bus.jump_btn = 1'b0;
    step(0);
    check("push_late", 32'(bus.jump_fire), 0);

    // reset at charge 7 with button held through reset
    bus.jump_btn = 1'b1;
    step(0);
    repeat (7) step(1);
    check("rst7_cnt", 32'(bus.charge_cnt), 7);
    #2;
    sys_rst_n = 1'b0;
    #1;
    outs_zero("rst7_async");
    check("rst7_pwr", 32'(bus.jump_power), 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    step(0);
    step(1);
    step(0);
    outs_zero("rst_held");
    bus.jump_btn = 1'b0;
    step(0);
    bus.jump_btn = 1'b1;
    step(0);
    check("rst_repress_chg", 32'(bus.charging), 1);
    check("rst_repress_cnt", 32'(bus.charge_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jump_charge_ctrl.md
JUMP_CHARGE_CTRL -- requirements
Module: jump_charge_ctrl

Interface
REQ-001 The block SHALL have parameter PHY_WIDTH, default 16, width of charge and power values.
REQ-002 The block SHALL have parameter MAX_CHARGE, default 40, saturation value of the charge counter in ticks.
REQ-003 The block SHALL have parameter MIN_CHARGE, default 2, minimum charge that produces a jump.
REQ-004 The block SHALL have parameter COOLDOWN_TICKS, default 4, ticks after a fire before a new charge may start.
REQ-005 The block SHALL have port sys_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port tick, input, 1, one-sys_clk-wide character-clock enable pulse.
REQ-008 The block SHALL have port jump_btn, input, 1, debounced jump level, 1 = pressed.
REQ-009 The block SHALL have port on_ground, input, 1, 1 = character standing on a platform.
REQ-010 The block SHALL have port charge_cnt, output, PHY_WIDTH, live charge value for the charge bar.
REQ-011 The block SHALL have port charging, output, 1, high while in CHARGE.
REQ-012 The block SHALL have port jump_fire, output, 1, one-sys_clk pulse requesting a jump.
REQ-013 The block SHALL have port jump_power, output, PHY_WIDTH, charge captured at fire, held until the next fire.

Function
REQ-014 The block SHALL implement FSM states IDLE, ARMED, CHARGE, FIRE, COOLDOWN.
REQ-015 The FSM SHALL evaluate transitions every sys_clk, but charge and cooldown counters SHALL advance only when tick=1.
REQ-016 In IDLE, a rising edge of jump_btn (registered previous level 0, current 1) with on_ground=1 SHALL move to CHARGE with charge_cnt=0.
REQ-017 In IDLE, jump_btn rising with on_ground=0 SHALL move to ARMED; edges while airborne do not queue.
REQ-018 In ARMED, on_ground=1 with jump_btn=1 SHALL move to CHARGE (charge_cnt=0); jump_btn=0 SHALL return to IDLE.
REQ-019 In CHARGE, each tick SHALL increment charge_cnt by 1, saturating at MAX_CHARGE (no wrap).
REQ-020 In CHARGE, jump_btn=0 SHALL move to FIRE if charge_cnt>=MIN_CHARGE, else to IDLE with charge_cnt cleared.
REQ-021 In CHARGE, on_ground=0 (pushed off platform) SHALL abort to IDLE, clear charge_cnt, and SHALL NOT fire.
REQ-022 When tick and release occur in the same cycle, the release SHALL win: no increment, transition uses the pre-tick charge_cnt.
REQ-023 FIRE SHALL last exactly one sys_clk: jump_fire=1, jump_power<=charge_cnt, charge_cnt<=0, then COOLDOWN.
REQ-024 COOLDOWN SHALL count COOLDOWN_TICKS ticks, then return to IDLE; jump_btn edges during COOLDOWN SHALL be ignored.
REQ-025 With COOLDOWN_TICKS=0, FIRE SHALL return directly to IDLE.
REQ-026 Latency from release sample to jump_fire SHALL be exactly 1 sys_clk.
REQ-027 charging SHALL be a registered decode of state==CHARGE; jump_fire SHALL be registered.
REQ-028 Unreachable state encodings SHALL recover to IDLE on the next clock with outputs cleared.

Reset
REQ-029 sys_rst_n=0 SHALL asynchronously force IDLE, charge_cnt=0, jump_power=0, jump_fire=0, charging=0, cooldown counter=0, previous-button register=0.
REQ-030 Reset asserted mid-CHARGE SHALL discard the charge with no jump_fire on or after deassertion.
REQ-031 After reset release with jump_btn already held, no charge SHALL start until jump_btn goes 0 then 1.

Verification
REQ-032 Ground, press, 10 ticks, release -> charge_cnt 1..10, one jump_fire, jump_power=10, charge_cnt=0, COOLDOWN 4 ticks then IDLE.
REQ-033 Ground, hold 60 ticks, release -> charge_cnt saturates at 40, jump_power=40.
REQ-034 Ground, press, 1 tick, release -> no jump_fire, IDLE, charge_cnt=0; same for release coinciding with the 2nd tick.
REQ-035 Press airborne, land 3 ticks later still held -> ARMED then CHARGE from 0; drop on_ground at charge 5 -> IDLE, no fire.
REQ-036 Re-press during COOLDOWN -> ignored; press after IDLE -> new CHARGE; reset at charge 7 -> all outputs 0, no fire.
